sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Synthesizable run controller that replaces hand-timed clock/reset stimulus for the pipelined MIPS core.
- Generates a parametrised CPU reset pulse and counts run cycles.
- Detects end of program and raises done, either on a PC self-loop, an external halt request or a cycle-budget timeout.
- Sits between the top-level clk/reset and the mips core; the bench watches done instead of a fixed run time.

Parameters:
- RST_CYCLES, 2, rising edges cpu_reset stays high after reset falls (>=1).
- MAX_CYCLES, 100000, RUN-cycle budget before timeout (>=2).
- STALL_LIMIT, 4, consecutive valid samples of an identical pc that mean "program ended" (>=2).
- CNT_W, 32, width of the cycle_cnt and instr_cnt counters.
- PC_W, 32, width of pc.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- halt_req  in  1  external stop request, sampled in RUN.
- pc  in  PC_W  current PC from the core.
- pc_valid  in  1  pc is meaningful this cycle.
- cpu_reset  out  1  registered reset to the core.
- running  out  1  high while in RUN.
- done  out  1  sticky end-of-run flag.
- timeout  out  1  sticky; done was caused by the cycle budget.
- cycle_cnt  out  CNT_W  RUN edges elapsed.
- instr_cnt  out  CNT_W  valid-pc count (see Optional Feature).

Behaviour:
- One clock, clk. reset is asynchronous, active-high. All state is cleared immediately on reset assertion, with no clock edge needed.
- Reset values:
  - state=HOLD, cpu_reset=1, running=0, done=0, timeout=0.
  - cycle_cnt=0, instr_cnt=0.
  - hold_cnt=0, run_len=0, last_pc=0, have_pc=0.
- HOLD state:
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==RST_CYCLES-1: go to RUN, cpu_reset<=0, running<=1.
  - Net effect: cpu_reset is high for exactly RST_CYCLES rising edges after reset falls.
- RUN state:
  - cycle_cnt increments every edge, including the terminating edge.
  - On a pc_valid edge:
    - if have_pc and pc==last_pc: run_len<=run_len+1; else run_len<=1.
    - last_pc<=pc, have_pc<=1.
  - Cycles with pc_valid low leave run_len and last_pc unchanged.
- Termination is evaluated on each RUN edge, in priority order:
  - (1) halt_req=1.
  - (2) pc_valid and pc==last_pc and run_len+1>=STALL_LIMIT.
  - (3) cycle_cnt==MAX_CYCLES-1.
  - Any hit: next state DONE, done<=1, running<=0. timeout<=1 only when (3) is the highest-priority hit.
- DONE state:
  - Absorbing; only reset exits it.
  - cycle_cnt and instr_cnt are frozen.
  - cpu_reset stays 0, and pc/halt_req are ignored.
- Counter width: cycle_cnt saturates at 2^CNT_W-1 and never wraps. The budget must satisfy MAX_CYCLES <= 2^CNT_W-1.
- Reset mid-operation, in any state: instant return to reset values, cpu_reset=1 asynchronously, then the full HOLD sequence restarts.
- Simultaneous halt_req and budget expiry: done=1, timeout=0.

Optional Feature:
- Macro: SIM_RUN_CTRL_TRACE_EN.
- Defined:
  - instr_cnt increments on each RUN edge with pc_valid=1, including the terminating edge.
  - It saturates at 2^CNT_W-1 and freezes in DONE.
- Undefined: instr_cnt is tied to constant 0 and no counter register is built. All other behaviour is identical.

Test Plan:
1. RST_CYCLES=2; reset high 0-19ns, clk period 10ns → cpu_reset=1 through the edges at 25ns and 35ns, 0 after 35ns; running=1 from 35ns.
2. STALL_LIMIT=4; pc_valid=1 with pc 0x3000, 0x3004, 0x3008, then 0x300c for 4 edges → done=1 and timeout=0 after the 7th RUN edge, cycle_cnt=7, running=0.
3. MAX_CYCLES=16; pc increments by 4 every cycle → after RUN edge 16: done=1, timeout=1, cycle_cnt=16; further clocks leave cycle_cnt=16.
4. MAX_CYCLES=5; halt_req=1 only on RUN edge 5 → done=1, timeout=0, cycle_cnt=5.
5. Assert reset 3ns after RUN edge 10 → cpu_reset=1, done=0, cycle_cnt=0 before the next edge; after release, the HOLD sequence of scenario 1 repeats.
6. SIM_RUN_CTRL_TRACE_EN defined; pc_valid toggles 1,0,… for 10 RUN edges with distinct pc → instr_cnt=5. Same run with the macro undefined → instr_cnt=0.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for the pipelined MIPS core.
// Holds the core in reset for RST_CYCLES edges, then counts run cycles
// until a halt request, a PC self-loop or the cycle budget ends the run.
// Optional build macro: SIM_RUN_CTRL_TRACE_EN enables the instr_cnt counter;
// without it instr_cnt is a constant 0 and no counter register exists.
module sim_run_ctrl #(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 100000,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int RUN_W  = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [RUN_W-1:0]  STALL_LAST  = RUN_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [RUN_W-1:0]  run_len, run_len_nxt;
    logic [PC_W-1:0]   last_pc, last_pc_nxt;
    logic              have_pc, have_pc_nxt;
    logic [CNT_W-1:0]  cycle_cnt_nxt;
    logic              cpu_reset_nxt, running_nxt, done_nxt, timeout_nxt;
    logic              pc_repeat, stop_halt, stop_stall, stop_budget;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values computed by the comb block.
        if (reset) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            run_len   <= '0;
            last_pc   <= '0;
            have_pc   <= 1'b0;
            cycle_cnt <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            run_len   <= run_len_nxt;
            last_pc   <= last_pc_nxt;
            have_pc   <= have_pc_nxt;
            cycle_cnt <= cycle_cnt_nxt;
            cpu_reset <= cpu_reset_nxt;
            running   <= running_nxt;
            done      <= done_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Next-state logic: reset hold, PC self-loop tracking and termination.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        run_len_nxt   = run_len;
        last_pc_nxt   = last_pc;
        have_pc_nxt   = have_pc;
        cycle_cnt_nxt = cycle_cnt;
        cpu_reset_nxt = cpu_reset;
        running_nxt   = running;
        done_nxt      = done;
        timeout_nxt   = timeout;
        pc_repeat     = (pc == last_pc);
        stop_halt     = 1'b0;
        stop_stall    = 1'b0;
        stop_budget   = 1'b0;

        case (state)
            ST_HOLD: begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = ST_RUN;
                    cpu_reset_nxt = 1'b0;
                    running_nxt   = 1'b1;
                end
            end

            ST_RUN: begin
                if (cycle_cnt != CNT_MAX) begin
                    cycle_cnt_nxt = cycle_cnt + CNT_W'(1);
                end
                if (pc_valid) begin
                    run_len_nxt = (have_pc && pc_repeat) ? run_len + RUN_W'(1) : RUN_W'(1);
                    last_pc_nxt = pc;
                    have_pc_nxt = 1'b1;
                end
                // run_len counts earlier identical samples; this edge adds one more.
                stop_halt   = halt_req;
                stop_stall  = pc_valid && pc_repeat && (run_len >= STALL_LAST);
                stop_budget = (cycle_cnt == BUDGET_LAST);
                if (stop_halt || stop_stall || stop_budget) begin
                    state_nxt   = ST_DONE;
                    done_nxt    = 1'b1;
                    running_nxt = 1'b0;
                    timeout_nxt = !stop_halt && !stop_stall;
                end
            end

            ST_DONE: begin
                // Absorbing: only reset leaves this state.
            end

            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
    end

`ifdef SIM_RUN_CTRL_TRACE_EN
    logic [CNT_W-1:0] instr_q;

    // Count valid PC samples seen during RUN, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
        end else if (state == ST_RUN && pc_valid && instr_q != CNT_MAX) begin
            instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign instr_cnt = instr_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: a table-driven reset/stall
// sequence, hand-written corner sequences, and randomized runs checked
// against a behavioural model kept in this file.
module tb_sim_run_ctrl;

    localparam int RST   = 2;
    localparam int MAXC  = 16;
    localparam int STALL = 4;
    localparam int CW    = 32;
    localparam int PW    = 32;

    logic          clk;
    logic          rst;
    logic          halt_req;
    logic [PW-1:0] pc;
    logic          pc_valid;
    logic          cpu_reset, running, done, timeout;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    int n_vec = 0;
    int n_bad = 0;

    sim_run_ctrl #(
        .RST_CYCLES (RST),
        .MAX_CYCLES (MAXC),
        .STALL_LIMIT(STALL),
        .CNT_W      (CW),
        .PC_W       (PW)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .halt_req (halt_req),
        .pc       (pc),
        .pc_valid (pc_valid),
        .cpu_reset(cpu_reset),
        .running  (running),
        .done     (done),
        .timeout  (timeout),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural reference model ----------------
    int          m_edges;   // clock edges seen since reset release (capped at RST)
    int          m_run;     // RUN edges counted
    bit          m_done;
    bit          m_to;
    int          m_instr;
    logic [31:0] hist[$];   // every valid pc sampled during RUN

    function automatic void model_reset();
        m_edges = 0;
        m_run   = 0;
        m_done  = 1'b0;
        m_to    = 1'b0;
        m_instr = 0;
        hist.delete();
    endfunction

    function automatic void model_edge(input logic v, input logic [31:0] p, input logic h);
        int  streak;
        bit  hit_stall, hit_budget;
        if (m_edges < RST) begin
            m_edges++;
        end else if (!m_done) begin
            streak = 0;
            if (v) begin
                for (int i = hist.size() - 1; i >= 0 && hist[i] == p; i--) streak++;
                streak++;
            end
            hit_stall  = v && (streak >= STALL);
            hit_budget = (m_run + 1 == MAXC);
            m_run++;
            if (v) begin
                m_instr++;
                hist.push_back(p);
            end
            if (h || hit_stall || hit_budget) begin
                m_done = 1'b1;
                m_to   = !h && !hit_stall;
            end
        end
    endfunction

    function automatic int exp_instr(input int cnt);
`ifdef SIM_RUN_CTRL_TRACE_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(m_edges < RST));
        check({tag, ".running"},   32'(running),   32'(m_edges >= RST && !m_done));
        check({tag, ".done"},      32'(done),      32'(m_done));
        check({tag, ".timeout"},   32'(timeout),   32'(m_to));
        check({tag, ".cycle_cnt"}, cycle_cnt,      32'(m_run));
        check({tag, ".instr_cnt"}, instr_cnt,      32'(exp_instr(m_instr)));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, ".running"},   32'(running),   32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".timeout"},   32'(timeout),   32'd0);
        check({tag, ".cycle_cnt"}, cycle_cnt,      32'd0);
        check({tag, ".instr_cnt"}, instr_cnt,      32'd0);
    endtask

    // Apply inputs, take one rising edge, advance the model, sample 1ns later.
    task automatic drive(input logic v, input logic [31:0] p, input logic h);
        pc_valid = v;
        pc       = p;
        halt_req = h;
        @(posedge clk);
        model_edge(v, p, h);
        #1;
    endtask

    // Called 1ns after an edge: reset asserts 3ns after that edge.
    task automatic apply_reset(input string tag);
        pc_valid = 1'b0;
        halt_req = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_reset_values(tag);
        @(posedge clk);
        #4 rst = 1'b0;
    endtask

    task automatic hold_phase(input string tag);
        drive(1'b0, 32'h0, 1'b0);
        check_model({tag, ".hold1"});
        drive(1'b0, 32'h0, 1'b0);
        check_model({tag, ".hold2"});
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        halt;
        logic        cpu_rst;
        logic        run;
        logic        dn;
        logic        to;
        int          cyc;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] prev_pc, rpc;
    logic        rv, rh;

    initial begin
        // Reset release after the 15ns edge, stall detection on 0x300c.
        // Halt in the two HOLD edges must be ignored.
        tbl[0] = '{1'b0, 32'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[3] = '{1'b1, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[4] = '{1'b1, 32'h3008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[5] = '{1'b1, 32'h300c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        tbl[6] = '{1'b1, 32'h300c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        tbl[7] = '{1'b1, 32'h300c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6};
        tbl[8] = '{1'b1, 32'h300c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7};
        tbl[9] = '{1'b1, 32'h300c, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7};

        rst      = 1'b1;
        pc_valid = 1'b0;
        pc       = '0;
        halt_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1 check_reset_values("por");
        @(posedge clk);
        #4 rst = 1'b0;                      // t = 19ns

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].pv, tbl[i].pc, tbl[i].halt);
            check($sformatf("tbl%0d.cpu_reset", i), 32'(cpu_reset), 32'(tbl[i].cpu_rst));
            check($sformatf("tbl%0d.running", i),   32'(running),   32'(tbl[i].run));
            check($sformatf("tbl%0d.done", i),      32'(done),      32'(tbl[i].dn));
            check($sformatf("tbl%0d.timeout", i),   32'(timeout),   32'(tbl[i].to));
            check($sformatf("tbl%0d.cycle_cnt", i), cycle_cnt,      32'(tbl[i].cyc));
        end

        // Budget expiry with an advancing pc, then frozen counters.
        apply_reset("budget.rst");
        hold_phase("budget");
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
            check_model($sformatf("budget.e%0d", i));
        end
        check("budget.done",    32'(done),    32'd1);
        check("budget.timeout", 32'(timeout), 32'd1);
        check("budget.cycle",   cycle_cnt,    32'd16);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5000, 1'b1);
            check("budget.frozen", cycle_cnt, 32'd16);
        end

        // Plain halt on RUN edge 5.
        apply_reset("halt5.rst");
        hold_phase("halt5");
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'h2000 + 32'(4 * i), 1'b0);
        drive(1'b1, 32'h2100, 1'b1);
        check("halt5.done",    32'(done),    32'd1);
        check("halt5.timeout", 32'(timeout), 32'd0);
        check("halt5.cycle",   cycle_cnt,    32'd5);
        check("halt5.running", 32'(running), 32'd0);

        // Halt on the same edge the budget expires: halt wins, no timeout.
        apply_reset("both.rst");
        hold_phase("both");
        for (int i = 1; i <= 15; i++) drive(1'b0, 32'h0, 1'b0);
        check("both.pre_done", 32'(done), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        check("both.done",    32'(done),    32'd1);
        check("both.timeout", 32'(timeout), 32'd0);
        check("both.cycle",   cycle_cnt,    32'd16);

        // Asynchronous reset 3ns after RUN edge 10, then HOLD repeats.
        apply_reset("mid.rst0");
        hold_phase("mid");
        for (int i = 1; i <= 10; i++) drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0);
        check("mid.cycle10", cycle_cnt, 32'd10);
        apply_reset("mid.async");
        drive(1'b0, 32'h0, 1'b0);
        check("mid.hold1.cpu_reset", 32'(cpu_reset), 32'd1);
        drive(1'b0, 32'h0, 1'b0);
        check("mid.hold2.cpu_reset", 32'(cpu_reset), 32'd0);
        check("mid.hold2.running",   32'(running),   32'd1);

        // Alternating pc_valid with distinct pcs: five valid samples.
        apply_reset("trace.rst");
        hold_phase("trace");
        for (int i = 0; i < 10; i++) drive(i % 2 == 0, 32'h6000 + 32'(8 * i), 1'b0);
        check("trace.instr_cnt", instr_cnt, 32'(exp_instr(5)));
        check("trace.cycle",     cycle_cnt, 32'd10);
        check("trace.done",      32'(done), 32'd0);

        // Randomized runs against the model.
        for (int ep = 0; ep < 20; ep++) begin
            apply_reset($sformatf("rnd%0d.rst", ep));
            hold_phase($sformatf("rnd%0d", ep));
            prev_pc = 32'h40;
            for (int k = 0; k < 40; k++) begin
                rv  = ($urandom_range(3) != 0);
                rpc = ($urandom_range(9) < 6) ? prev_pc : 32'h40 + 32'(4 * $urandom_range(3));
                rh  = ($urandom_range(39) == 0);
                drive(rv, rpc, rh);
                check_model($sformatf("rnd%0d.e%0d", ep, k));
                prev_pc = rpc;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
